// File: rtl/stopwatch_display.sv
// stopwatch_display: snapshots the stopwatch's packed BCD count and scans it onto
// an active-low, time-multiplexed 3-digit seven-segment display with zero blanking.
module stopwatch_display #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic        i_sys_clk,
    input  logic        i_reset,
    input  logic        i_display_enb,
    input  logic [11:0] i_count_in,
    output logic        o_latch_count,
    output logic [6:0]  o_seg_n,
    output logic [2:0]  o_dig_n,
    output logic        o_bcd_err
);
    localparam int TW = $clog2(REFRESH_DIV);
    typedef enum logic [1:0] {IDLE, REQ, CAP, SCAN} state_t;
    state_t        r_state, w_state_nx;
    logic [TW-1:0] r_tmr, w_tmr_nx;
    logic [1:0]    r_dig, w_dig_nx;
    logic [11:0]   r_shadow, w_val;
    logic [3:0]    w_nib;
    logic          w_blank, w_lit;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_tmr_nx   = r_tmr;
        w_dig_nx   = r_dig;
        if (!i_display_enb) begin
            w_state_nx = IDLE;
            w_tmr_nx   = '0;
            w_dig_nx   = '0;
        end else begin
            case (r_state)
                IDLE: w_state_nx = REQ;
                REQ:  w_state_nx = CAP;
                CAP: begin
                    w_state_nx = SCAN;
                    w_tmr_nx   = '0;
                    w_dig_nx   = '0;
                end
                default: begin
                    w_tmr_nx = (r_tmr == TW'(REFRESH_DIV - 1)) ? '0 : r_tmr + 1'b1;
                    if (r_tmr == TW'(REFRESH_DIV - 1)) begin
                        w_dig_nx   = (r_dig == 2'd2) ? 2'd0 : r_dig + 2'd1;
                        w_state_nx = (r_dig == 2'd2) ? REQ : SCAN;
                    end
                end
            endcase
        end
    end

    // Outputs are registered from next-state values; the capture cycle feeds
    // count_in straight through so the units slot is correct on its first cycle.
    assign w_val   = (r_state == CAP) ? i_count_in : r_shadow;
    assign w_nib   = (w_dig_nx == 2'd2) ? w_val[11:8] : (w_dig_nx == 2'd1) ? w_val[7:4] : w_val[3:0];
    assign w_blank = (w_dig_nx == 2'd2 && w_val[11:8] == 4'd0) || (w_dig_nx == 2'd1 && w_val[11:4] == 8'd0);
    assign w_lit   = (w_state_nx == SCAN) && !w_blank;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_tmr         <= '0;
            r_dig         <= '0;
            r_shadow      <= '0;
            o_latch_count <= 1'b0;
            o_seg_n       <= 7'h7F;
            o_dig_n       <= 3'b111;
            o_bcd_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_tmr         <= w_tmr_nx;
            r_dig         <= w_dig_nx;
            o_latch_count <= (w_state_nx == REQ);
            o_seg_n       <= w_lit ? seg7(w_nib) : 7'h7F;
            o_dig_n       <= w_lit ? ~(3'b001 << w_dig_nx) : 3'b111;
            if (r_state == CAP) begin
                r_shadow  <= i_count_in;
                o_bcd_err <= (i_count_in[11:8] > 4'd9) | (i_count_in[7:4] > 4'd9) | (i_count_in[3:0] > 4'd9);
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: directed frames with REFRESH_DIV=4; per-cycle expected
// outputs are queued per frame and popped against the DUT each cycle.
module tb_stopwatch_display;
    localparam int R = 4;
    logic        clk = 1'b0, reset, enb;
    logic [11:0] count_in;
    logic        latch, err;
    logic [6:0]  seg;
    logic [2:0]  dig;
    int          checks = 0, errors = 0;
    logic        exp_err = 1'b0;

    typedef struct {
        logic [6:0] seg;
        logic       segc;
        logic [2:0] dig;
        logic       lat;
        logic       err;
    } exp_t;
    exp_t q[$];

    logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                             7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    stopwatch_display #(.REFRESH_DIV(R)) dut (
        .i_sys_clk(clk), .i_reset(reset), .i_display_enb(enb), .i_count_in(count_in),
        .o_latch_count(latch), .o_seg_n(seg), .o_dig_n(dig), .o_bcd_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        @(posedge clk); #1;
        e = q.pop_front();
        chk({tag, " dig_n"}, 7'(dig), 7'(e.dig));
        chk({tag, " latch"}, 7'(latch), 7'(e.lat));
        chk({tag, " bcd_err"}, 7'(err), 7'(e.err));
        if (e.segc) chk({tag, " seg_n"}, seg, e.seg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back('{7'h7F, 1'b1, 3'b111, 1'b0, exp_err});
            pop_cmp($sformatf("idle%0d", i));
        end
    endtask

    task automatic frame(input logic [11:0] c, input logic [11:0] c2, input int kchg, input int kend);
        logic new_err, blank;
        int   s;
        new_err = (c[11:8] > 9) || (c[7:4] > 9) || (c[3:0] > 9);
        count_in = c;
        for (int k = 0; k <= kend; k++) begin
            if (k < 2) q.push_back('{7'h7F, 1'b1, 3'b111, k == 0, exp_err});
            else begin
                s = (k - 2) / R;
                blank = (s == 2 && c[11:8] == 0) || (s == 1 && c[11:4] == 0);
                q.push_back('{tab[c[4*s +: 4]], !blank, blank ? 3'b111 : ~(3'(1) << s), 1'b0, new_err});
            end
        end
        for (int k = 0; k <= kend; k++) begin
            pop_cmp($sformatf("frame %h k%0d", c, k));
            if (k == kchg) count_in = c2;
        end
        if (kend >= 2) exp_err = new_err;
    endtask

    initial begin
        reset = 1'b1; enb = 1'b1; count_in = 12'h385;
        idle(3);
        reset = 1'b0;
        frame(12'h385, 12'h385, -1, 13);
        frame(12'h007, 12'h007, -1, 13);
        frame(12'h040, 12'h040, -1, 13);
        frame(12'h000, 12'h000, -1, 13);
        frame(12'h1A3, 12'h1A3, -1, 13);
        frame(12'h123, 12'h123, -1, 13);
        frame(12'h111, 12'h999, 4, 13);
        frame(12'h999, 12'h999, -1, 13);
        frame(12'h222, 12'h222, -1, 7);
        enb = 1'b0;
        idle(20);
        enb = 1'b1;
        frame(12'h456, 12'h456, -1, 13);
        frame(12'hF05, 12'hF05, -1, 13);
        frame(12'h385, 12'h385, -1, 7);
        reset = 1'b1;
        exp_err = 1'b0;
        idle(1);
        reset = 1'b0;
        frame(12'h385, 12'h385, -1, 13);
        frame(12'h060, 12'h060, -1, 13);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
